serial_wb_unit: RTL

- Writeback stage directly downstream of the bit-serial ALU in the UltraSmall core. It deserializes the ALU result stream (1 bit/cycle, LSB first) or takes a parallel value (load data, link PC+4, U-immediate) and commits it into the 32x32 register file.
- Owns the register file and provides the two combinational read ports used by decode.
- Handshakes with the core FSM through start, busy and done.

---
 rtl/serial_wb_unit_pkg.sv | 45 ++++
 rtl/serial_wb_unit_if.sv | 34 +++
 rtl/serial_wb_unit_wb_regfile.sv | 36 +++
 rtl/serial_wb_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/serial_wb_unit_pkg.sv
// Shared encodings for the serial writeback unit: FSM states, source selects, load widths.
// Also holds the byte/half load extension used when WB_SUBWORD_LOAD_EN is defined.
package serial_wb_unit_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_NREG = 32;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_COLLECT = 2'd1,
        WB_COMMIT  = 2'd2
    } wb_state_t;

    localparam logic [1:0] WB_SRC_ALU  = 2'd0;
    localparam logic [1:0] WB_SRC_LD   = 2'd1;
    localparam logic [1:0] WB_SRC_LINK = 2'd2;
    localparam logic [1:0] WB_SRC_IMM  = 2'd3;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Halfword loads look at off[1] only; unknown funct3 falls back to a full word.
    function automatic logic [WB_XLEN-1:0] ld_extend(input logic [WB_XLEN-1:0] d,
                                                     input logic [2:0]         f3,
                                                     input logic [1:0]         off);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [WB_XLEN-1:0] r;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            LD_LB:   r = {{(WB_XLEN-8){b[7]}}, b};
            LD_LH:   r = {{(WB_XLEN-16){h[15]}}, h};
            LD_LBU:  r = {{(WB_XLEN-8){1'b0}}, b};
            LD_LHU:  r = {{(WB_XLEN-16){1'b0}}, h};
            LD_LW:   r = d;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_wb_unit_if.sv
// Core-side bundle of the writeback unit: start/source/serial stream in, read ports and status out.
// slave = the writeback unit, master = the core FSM / decode side.
interface serial_wb_unit_if import serial_wb_unit_pkg::*; #(parameter int XLEN = WB_XLEN) ();

    logic            w_wb_start;
    logic [4:0]      w_wb_rd;
    logic            w_wb_we;
    logic [1:0]      w_wb_src;
    logic [XLEN-1:0] w_par_data;
    logic [2:0]      w_ld_funct3;
    logic [1:0]      w_ld_off;
    logic            w_ser_bit;
    logic            w_ser_vld;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic            w_busy;
    logic            w_done;
    logic [XLEN-1:0] w_rout;

    modport slave (
        input  w_wb_start, w_wb_rd, w_wb_we, w_wb_src, w_par_data, w_ld_funct3, w_ld_off,
        input  w_ser_bit, w_ser_vld, w_rs1, w_rs2,
        output w_rdata1, w_rdata2, w_busy, w_done, w_rout
    );

    modport master (
        output w_wb_start, w_wb_rd, w_wb_we, w_wb_src, w_par_data, w_ld_funct3, w_ld_off,
        output w_ser_bit, w_ser_vld, w_rs1, w_rs2,
        input  w_rdata1, w_rdata2, w_busy, w_done, w_rout
    );

endinterface

// File: rtl/serial_wb_unit_wb_regfile.sv
// Register file with two combinational read ports, one write port and x0 tied to zero.
// Reads of the register being committed return the pending write data (same-cycle bypass).
module wb_regfile import serial_wb_unit_pkg::*; #(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            byp,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (byp && ra1 == wa) rd1 = wd;
        if (byp && ra2 == wa) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/serial_wb_unit.sv
// Writeback stage: deserializes the LSB-first ALU stream or takes a parallel value, then commits it.
// Latency 1 cycle (parallel) / 33 + stalls (serial); start ignored while busy. Optional: WB_SUBWORD_LOAD_EN.
module serial_wb_unit import serial_wb_unit_pkg::*; #(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG
) (
    input logic              w_clk,
    input logic              w_rst,
    serial_wb_unit_if.slave  bus
);

    wb_state_t       r_state;
    wb_state_t       nxt_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [4:0]      r_rd;
    logic [1:0]      r_src;
    logic [XLEN-1:0] r_rout;
    logic [XLEN-1:0] par_val;
    logic            commit;
    logic            unused_bits;

`ifdef WB_SUBWORD_LOAD_EN
    assign par_val     = (bus.w_wb_src == WB_SRC_LD) ?
                         ld_extend(bus.w_par_data, bus.w_ld_funct3, bus.w_ld_off) : bus.w_par_data;
    assign unused_bits = ^r_src;
`else
    assign par_val     = bus.w_par_data;
    assign unused_bits = ^{r_src, bus.w_ld_funct3, bus.w_ld_off};
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) r_state <= WB_IDLE;
        else       r_state <= nxt_state;
    end

    always_comb begin
        nxt_state  = r_state;
        bus.w_busy = (r_state != WB_IDLE);
        bus.w_done = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (bus.w_wb_start) begin
                    nxt_state = (bus.w_wb_src == WB_SRC_ALU) ? WB_COLLECT : WB_COMMIT;
                end
            end
            WB_COLLECT: begin
                // Exit is decided on the pre-wrap count of the 32nd valid bit.
                if (bus.w_ser_vld && r_cnt == 5'd31) nxt_state = WB_COMMIT;
            end
            WB_COMMIT: begin
                bus.w_done = 1'b1;
                nxt_state  = WB_IDLE;
            end
            default: nxt_state = WB_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_rd   <= '0;
            r_src  <= WB_SRC_ALU;
            r_rout <= '0;
        end else begin
            case (r_state)
                WB_IDLE: begin
                    if (bus.w_wb_start) begin
                        r_rd  <= bus.w_wb_we ? bus.w_wb_rd : 5'd0;
                        r_src <= bus.w_wb_src;
                        if (bus.w_wb_src == WB_SRC_ALU) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_acc <= par_val;
                        end
                    end
                end
                WB_COLLECT: begin
                    if (bus.w_ser_vld) begin
                        r_acc <= {bus.w_ser_bit, r_acc[XLEN-1:1]};
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                WB_COMMIT: begin
                    if (r_rd != 5'd0) r_rout <= r_acc;
                end
                default: ;
            endcase
        end
    end

    // A reset landing on the commit edge must suppress the register write.
    assign commit = (r_state == WB_COMMIT);

    wb_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk (w_clk),
        .we  (commit && !w_rst),
        .byp (commit),
        .wa  (r_rd),
        .wd  (r_acc),
        .ra1 (bus.w_rs1),
        .ra2 (bus.w_rs2),
        .rd1 (bus.w_rdata1),
        .rd2 (bus.w_rdata2)
    );

    assign bus.w_rout = r_rout;

endmodule
